rtc_bus_arbiter: RTL and testbench
==================================

Name: rtc_bus_arbiter

Overview:
Shares the single multiplexed address/data RTC bus (AD, RD, WR, CS, 8-bit bus) between three requesters: the power-up programming sequencer (R0), the user time-edit path (R1) and the periodic time-read poller (R2).
Each granted request is run as one complete bus cycle with parametrised phase timing. Read data is returned to the requester, and every completed transaction is acknowledged with a one-cycle pulse.
Sits between the clock-programming/display logic and the RTC chip pins.

Parameters:
T_PHASE, 4, clock cycles per bus phase (>=1)
ADDR_W, 8, RTC register address width
DATA_W, 8, RTC data width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Req  in  3  per-requester request level; bit i = Ri
We  in  3  per-requester write enable (1 = write, 0 = read)
Dir0, Dir1, Dir2  in  ADDR_W each  per-requester RTC register address
Dato0, Dato1, Dato2  in  DATA_W each  per-requester write data
Ack  out  3  one-hot, one-cycle completion pulse
Gnt  out  3  one-hot; high for the whole transaction of the granted requester
Dato_Leido  out  DATA_W  captured read data; valid while Ack is high, held until the next read
Bus_In  in  DATA_W  RTC bus input (pad side)
Bus_Out  out  DATA_W  RTC bus output value
Bus_OE  out  1  bus output enable (1 = drive)
AD  out  1  address/data select (0 = address phase)
RD  out  1  read strobe, active-low
WR  out  1  write strobe, active-low
CS  out  1  chip select, active-low

Behaviour:
- Reset (asynchronous, Reset=0):
  - state=IDLE; CS=RD=WR=AD=1; Bus_OE=0.
  - Bus_Out, Dato_Leido, Gnt, Ack all 0; round-robin pointer at R1.
  - Reset mid-transaction aborts the cycle immediately with no Ack.
- FSM: IDLE -> ADDR -> ADDR_HOLD -> DATA -> DATA_HOLD -> RECOVER -> IDLE. Every state except IDLE lasts exactly T_PHASE cycles, counted by a phase counter.
- Arbitration, IDLE only:
  - The winner is latched (Gnt, We, Dir, Dato) on the edge leaving IDLE.
  - Req is sampled at that edge; a Req dropped before it is ignored.
  - Request inputs are ignored during a transaction.
- Pin values per state:
  - IDLE: CS=1, RD=1, WR=1, AD=1, Bus_OE=0.
  - ADDR: CS=0, AD=0, WR=0, Bus_OE=1, Bus_Out=latched Dir.
  - ADDR_HOLD: CS=0, AD=0, WR=1, Bus_OE=1, Bus_Out=latched Dir.
  - DATA, write: CS=0, AD=1, WR=0, Bus_OE=1, Bus_Out=latched Dato.
  - DATA, read: CS=0, AD=1, RD=0, Bus_OE=0; Dato_Leido<=Bus_In on the last DATA cycle.
  - DATA_HOLD: CS=0, AD=1, RD=WR=1; a write keeps driving data, a read keeps Bus_OE=0.
  - RECOVER: as IDLE.
- Completion and latency:
  - Ack[granted] pulses for one cycle on the first cycle back in IDLE; Gnt clears the same edge.
  - Latency: Req seen at edge k -> ADDR from k+1 -> Ack high at k+1+5*T_PHASE (21 for T_PHASE=4).
- Boundary cases:
  - At least one IDLE cycle between transactions; back-to-back requests re-arbitrate there.
  - A requester that holds Req through its own Ack is re-served (level-sensitive); requesters drop Req on Ack.
  - Simultaneous requests: resolved by the priority rule below.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: R0 has absolute priority. R1 and R2 alternate; the pointer moves to the other requester after either one is served.
- Undefined: fixed priority R0 > R1 > R2, and R2 can starve.

Decomposition:
- Package rtc_bus_pkg: FSM state enum, requester index constants (REQ_PROG=0, REQ_EDIT=1, REQ_POLL=2), default T_PHASE, ADDR_W/DATA_W.
- Sub-module rtc_bus_cycle: the FSM, phase counter, pin drive and read capture, started by a start/we/addr/data interface that returns done.
- rtc_bus_arbiter keeps the arbitration, latching, Gnt/Ack generation and round-robin pointer.

Test Plan:
1. Single write: Req=001, We=001, Dir0=8'h21, Dato0=8'h45 -> Bus_Out=21 with AD=0 for 8 cycles, then 45 with WR=0 for 4 cycles, CS low for 16 cycles, Ack=001 at cycle 21.
2. Single read: Req=100, Dir2=8'h22, Bus_In=8'h59 -> RD=0 for 4 cycles with Bus_OE=0, Dato_Leido=59 while Ack=100.
3. Simultaneous Req=111:
   - R0 is served first in both builds.
   - Without ARB_ROUND_ROBIN_EN: R1 then R2.
   - With it, R1/R2 alternate over four repeated requests.
4. Reset=0 at cycle 10 of a write -> CS, WR, AD high and Bus_OE=0 in the same cycle, no Ack. After release, a new request completes normally.
5. Req=010 dropped mid-transaction -> the cycle still completes and Ack=010. Req=010 dropped before leaving IDLE -> no transaction.
6. T_PHASE=1 -> Ack 6 cycles after the Req sampling edge; strobe widths are 1 cycle.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared types and constants for the RTC bus arbiter slice.
// Holds the bus-cycle state encoding, the requester indices, the default
// timing/width values, and the pin decode used by the bus-cycle engine.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_HOLD = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_HOLD = 3'd4,
        ST_RECOVER   = 3'd5
    } bus_state_t;

    localparam int N_REQ    = 3;
    localparam int REQ_PROG = 0;   // power-up programming sequencer
    localparam int REQ_EDIT = 1;   // user time-edit path
    localparam int REQ_POLL = 2;   // periodic time-read poller

    localparam int T_PHASE_DEF = 4;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;

    // Control pins of the RTC chip; strobes are active-low.
    typedef struct packed {
        logic cs;
        logic rd;
        logic wr;
        logic ad;
        logic oe;
    } pins_t;

    localparam pins_t PINS_IDLE = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, ad: 1'b1, oe: 1'b0};

    // Pin levels for a given bus state; we selects write vs read behaviour
    // in the data phases.
    function automatic pins_t pin_decode(input bus_state_t st, input logic we);
        pins_t p;
        p = PINS_IDLE;
        case (st)
            ST_ADDR: begin
                p.cs = 1'b0;
                p.ad = 1'b0;
                p.wr = 1'b0;
                p.oe = 1'b1;
            end
            ST_ADDR_HOLD: begin
                p.cs = 1'b0;
                p.ad = 1'b0;
                p.oe = 1'b1;
            end
            ST_DATA: begin
                p.cs = 1'b0;
                p.ad = 1'b1;
                p.wr = ~we;
                p.rd = we;
                p.oe = we;
            end
            ST_DATA_HOLD: begin
                p.cs = 1'b0;
                p.ad = 1'b1;
                p.oe = we;
            end
            default: p = PINS_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: runs one complete multiplexed RTC bus cycle per start.
// Sequence IDLE -> ADDR -> ADDR_HOLD -> DATA -> DATA_HOLD -> RECOVER -> IDLE,
// each non-idle state lasting T_PHASE clocks. Pins are registered from the
// next-state decode so they change cleanly on the clock edge and return to
// their idle levels immediately on reset.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = T_PHASE_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              idle,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              ad,
    output logic              rd,
    output logic              wr,
    output logic              cs
);

    localparam int CNT_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_PHASE - 1);

    bus_state_t          state;
    bus_state_t          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                phase_last;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_eff;
    logic [ADDR_W-1:0]   addr_eff;
    logic [DATA_W-1:0]   wdata_eff;
    pins_t               pins_q;
    pins_t               pins_nxt;
    logic [DATA_W-1:0]   bus_out_q;
    logic [DATA_W-1:0]   bus_out_nxt;

    assign phase_last = (cnt == CNT_LAST);
    assign idle       = (state == ST_IDLE);
    assign done       = (state == ST_RECOVER) && phase_last;

    // While idle the incoming request is what the next state will drive.
    assign we_eff    = idle ? we    : we_q;
    assign addr_eff  = idle ? addr  : addr_q;
    assign wdata_eff = idle ? wdata : wdata_q;

    // Next-state sequencing and registered pin/bus values for that state.
    always_comb begin
        state_nxt   = state;
        pins_nxt    = PINS_IDLE;
        bus_out_nxt = '0;
        case (state)
            ST_IDLE:      if (start)      state_nxt = ST_ADDR;
            ST_ADDR:      if (phase_last) state_nxt = ST_ADDR_HOLD;
            ST_ADDR_HOLD: if (phase_last) state_nxt = ST_DATA;
            ST_DATA:      if (phase_last) state_nxt = ST_DATA_HOLD;
            ST_DATA_HOLD: if (phase_last) state_nxt = ST_RECOVER;
            ST_RECOVER:   if (phase_last) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
        pins_nxt = pin_decode(state_nxt, we_eff);
        if (state_nxt == ST_ADDR || state_nxt == ST_ADDR_HOLD) begin
            bus_out_nxt = DATA_W'(addr_eff);
        end else if ((state_nxt == ST_DATA || state_nxt == ST_DATA_HOLD) && we_eff) begin
            bus_out_nxt = wdata_eff;
        end
    end

    // State, phase counter and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pins_q    <= PINS_IDLE;
            bus_out_q <= '0;
        end else begin
            state     <= state_nxt;
            pins_q    <= pins_nxt;
            bus_out_q <= bus_out_nxt;
            if (idle || phase_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Latch the transaction on start and capture read data at the end of DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_data <= '0;
        end else begin
            if (idle && start) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == ST_DATA && phase_last && !we_q) begin
                rd_data <= bus_in;
            end
        end
    end

    assign bus_out = bus_out_q;
    assign bus_oe  = pins_q.oe;
    assign ad      = pins_q.ad;
    assign rd      = pins_q.rd;
    assign wr      = pins_q.wr;
    assign cs      = pins_q.cs;

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares the RTC bus between the programming sequencer (R0),
// the time-edit path (R1) and the time-read poller (R2). Arbitrates only
// while the bus is idle, latches the winner, and pulses Ack on completion.
// Build option ARB_ROUND_ROBIN_EN: R0 keeps absolute priority while R1 and
// R2 alternate; without it priority is fixed R0 > R1 > R2.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = T_PHASE_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [2:0]        Req,
    input  logic [2:0]        We,
    input  logic [ADDR_W-1:0] Dir0,
    input  logic [ADDR_W-1:0] Dir1,
    input  logic [ADDR_W-1:0] Dir2,
    input  logic [DATA_W-1:0] Dato0,
    input  logic [DATA_W-1:0] Dato1,
    input  logic [DATA_W-1:0] Dato2,
    output logic [2:0]        Ack,
    output logic [2:0]        Gnt,
    output logic [DATA_W-1:0] Dato_Leido,
    input  logic [DATA_W-1:0] Bus_In,
    output logic [DATA_W-1:0] Bus_Out,
    output logic              Bus_OE,
    output logic              AD,
    output logic              RD,
    output logic              WR,
    output logic              CS
);

    logic [N_REQ-1:0]  win;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  ack_q;
    logic              start;
    logic              cyc_idle;
    logic              cyc_done;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr;   // 0: R1 preferred next, 1: R2 preferred next

    // Winner selection: R0 absolute, then R1/R2 by the alternating pointer.
    always_comb begin
        win = '0;
        if (Req[REQ_PROG]) begin
            win[REQ_PROG] = 1'b1;
        end else if (Req[REQ_EDIT] && (!rr_ptr || !Req[REQ_POLL])) begin
            win[REQ_EDIT] = 1'b1;
        end else if (Req[REQ_POLL]) begin
            win[REQ_POLL] = 1'b1;
        end
    end

    // Move the pointer to the other of R1/R2 whenever one of them is served.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rr_ptr <= 1'b0;
        end else if (start && (win[REQ_EDIT] || win[REQ_POLL])) begin
            rr_ptr <= win[REQ_EDIT];
        end
    end
`else
    // Winner selection: fixed priority R0 > R1 > R2.
    always_comb begin
        win = '0;
        if (Req[REQ_PROG]) begin
            win[REQ_PROG] = 1'b1;
        end else if (Req[REQ_EDIT]) begin
            win[REQ_EDIT] = 1'b1;
        end else if (Req[REQ_POLL]) begin
            win[REQ_POLL] = 1'b1;
        end
    end
`endif

    // Request inputs only matter while the bus engine is idle.
    assign start = cyc_idle && (|Req);

    // Route the winner's transaction fields to the bus engine.
    always_comb begin
        sel_we   = |(We & win);
        sel_addr = Dir2;
        sel_data = Dato2;
        if (win[REQ_PROG]) begin
            sel_addr = Dir0;
            sel_data = Dato0;
        end else if (win[REQ_EDIT]) begin
            sel_addr = Dir1;
            sel_data = Dato1;
        end
    end

    // Grant held for the whole transaction; Ack pulses once as Gnt clears.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            gnt_q <= '0;
            ack_q <= '0;
        end else begin
            ack_q <= '0;
            if (cyc_done) begin
                ack_q <= gnt_q;
                gnt_q <= '0;
            end else if (start) begin
                gnt_q <= win;
            end
        end
    end

    rtc_bus_cycle #(
        .T_PHASE (T_PHASE),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_cycle (
        .clk     (Clock),
        .rst_n   (Reset),
        .start   (start),
        .we      (sel_we),
        .addr    (sel_addr),
        .wdata   (sel_data),
        .idle    (cyc_idle),
        .done    (cyc_done),
        .rd_data (Dato_Leido),
        .bus_in  (Bus_In),
        .bus_out (Bus_Out),
        .bus_oe  (Bus_OE),
        .ad      (AD),
        .rd      (RD),
        .wr      (WR),
        .cs      (CS)
    );

    assign Gnt = gnt_q;
    assign Ack = ack_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed vectors for rtc_bus_arbiter with hand-computed
// expectations. u_dut runs T_PHASE=4, u_dut_f runs T_PHASE=1.
module tb_rtc_bus_arbiter;

    logic       Clock;
    logic       Reset;
    logic [2:0] Req;
    logic [2:0] We;
    logic [7:0] Dir0, Dir1, Dir2;
    logic [7:0] Dato0, Dato1, Dato2;
    logic [7:0] Bus_In;

    logic [2:0] Ack, Gnt;
    logic [7:0] Dato_Leido, Bus_Out;
    logic       Bus_OE, AD, RD, WR, CS;

    logic [2:0] req_f;
    logic [2:0] ack_f, gnt_f;
    logic [7:0] leido_f, bus_out_f;
    logic       oe_f, ad_f, rd_f, wr_f, cs_f;

    int vectors = 0;
    int miscompares = 0;

    int lat, n_cs, n_ad0_addr, n_wr_data, n_rd, n_oe, n_gnt;
    logic [2:0] ack_val, gnt_at_ack;
    logic [7:0] leido_at_ack;

    rtc_bus_arbiter #(.T_PHASE(4), .ADDR_W(8), .DATA_W(8)) u_dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .We(We),
        .Dir0(Dir0), .Dir1(Dir1), .Dir2(Dir2),
        .Dato0(Dato0), .Dato1(Dato1), .Dato2(Dato2),
        .Ack(Ack), .Gnt(Gnt), .Dato_Leido(Dato_Leido),
        .Bus_In(Bus_In), .Bus_Out(Bus_Out), .Bus_OE(Bus_OE),
        .AD(AD), .RD(RD), .WR(WR), .CS(CS)
    );

    rtc_bus_arbiter #(.T_PHASE(1), .ADDR_W(8), .DATA_W(8)) u_dut_f (
        .Clock(Clock), .Reset(Reset), .Req(req_f), .We(We),
        .Dir0(Dir0), .Dir1(Dir1), .Dir2(Dir2),
        .Dato0(Dato0), .Dato1(Dato1), .Dato2(Dato2),
        .Ack(ack_f), .Gnt(gnt_f), .Dato_Leido(leido_f),
        .Bus_In(Bus_In), .Bus_Out(bus_out_f), .Bus_OE(oe_f),
        .AD(ad_f), .RD(rd_f), .WR(wr_f), .CS(cs_f)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Follow one transaction of u_dut from its sampling edge until Ack.
    task automatic watch(input logic [2:0] exp_gnt, input logic [7:0] ea, input logic [7:0] ed,
                         input int drop_at, input bit hold);
        lat = 0; n_cs = 0; n_ad0_addr = 0; n_wr_data = 0; n_rd = 0; n_oe = 0; n_gnt = 0;
        ack_val = '0; gnt_at_ack = '0; leido_at_ack = '0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == drop_at) Req = 3'b000;
            if (Ack != 3'b000) begin
                lat = n;
                ack_val = Ack;
                gnt_at_ack = Gnt;
                leido_at_ack = Dato_Leido;
                if (!hold) Req = Req & ~Ack;
                break;
            end
            if (!CS) n_cs++;
            if (!AD && Bus_OE && Bus_Out == ea) n_ad0_addr++;
            if (!WR && AD && Bus_OE && Bus_Out == ed) n_wr_data++;
            if (!RD && AD && !Bus_OE && !CS) n_rd++;
            if (Bus_OE) n_oe++;
            if (Gnt == exp_gnt) n_gnt++;
        end
    endtask

    function automatic logic [7:0] dir_of(input logic [2:0] g);
        return g[0] ? 8'h31 : (g[1] ? 8'h32 : 8'h33);
    endfunction

    function automatic logic [7:0] dato_of(input logic [2:0] g);
        return g[0] ? 8'h41 : (g[1] ? 8'h42 : 8'h43);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq3 [3];
        logic [2:0] seq4 [4];
        int bad;

        Reset = 1'b0; Req = '0; req_f = '0; We = '0;
        Dir0 = '0; Dir1 = '0; Dir2 = '0; Dato0 = '0; Dato1 = '0; Dato2 = '0; Bus_In = '0;
        tick(); tick();

        // Reset state
        chk("rst_cs", CS, 1'b1);
        chk("rst_rd", RD, 1'b1);
        chk("rst_wr", WR, 1'b1);
        chk("rst_ad", AD, 1'b1);
        chk("rst_oe", Bus_OE, 1'b0);
        chk("rst_bus_out", Bus_Out, 8'h00);
        chk("rst_leido", Dato_Leido, 8'h00);
        chk("rst_gnt", Gnt, 3'b000);
        chk("rst_ack", Ack, 3'b000);
        Reset = 1'b1;
        tick(); tick();

        // 1. Single write by R0
        We = 3'b001; Dir0 = 8'h21; Dato0 = 8'h45; Req = 3'b001;
        watch(3'b001, 8'h21, 8'h45, 0, 0);
        chk("wr_latency", lat, 21);
        chk("wr_ack", ack_val, 3'b001);
        chk("wr_gnt_clear", gnt_at_ack, 3'b000);
        chk("wr_gnt_cycles", n_gnt, 20);
        chk("wr_addr_cycles", n_ad0_addr, 8);
        chk("wr_data_cycles", n_wr_data, 4);
        chk("wr_cs_cycles", n_cs, 16);
        chk("wr_oe_cycles", n_oe, 16);
        tick();
        chk("wr_ack_one_cycle", Ack, 3'b000);
        chk("wr_idle_cs", CS, 1'b1);

        // 2. Single read by R2
        We = 3'b000; Dir2 = 8'h22; Bus_In = 8'h59; Req = 3'b100;
        watch(3'b100, 8'h22, 8'h00, 0, 0);
        chk("rd_latency", lat, 21);
        chk("rd_ack", ack_val, 3'b100);
        chk("rd_leido", leido_at_ack, 8'h59);
        chk("rd_strobe_cycles", n_rd, 4);
        chk("rd_oe_cycles", n_oe, 8);
        chk("rd_addr_cycles", n_ad0_addr, 8);
        chk("rd_cs_cycles", n_cs, 16);
        tick();

        // 3a. Simultaneous requests, each requester drops Req on its Ack
        We = 3'b111;
        Dir0 = 8'h31; Dir1 = 8'h32; Dir2 = 8'h33;
        Dato0 = 8'h41; Dato1 = 8'h42; Dato2 = 8'h43;
        seq3 = '{3'b001, 3'b010, 3'b100};
        Req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            watch(seq3[i], dir_of(seq3[i]), dato_of(seq3[i]), 0, 0);
            chk($sformatf("sim_ack_%0d", i), ack_val, seq3[i]);
            chk($sformatf("sim_latency_%0d", i), lat, 21);
            chk($sformatf("sim_addr_%0d", i), n_ad0_addr, 8);
            chk($sformatf("sim_data_%0d", i), n_wr_data, 4);
        end
        chk("leido_held", Dato_Leido, 8'h59);

        // 3b. R1 and R2 keep requesting through their Acks
`ifdef ARB_ROUND_ROBIN_EN
        seq4 = '{3'b010, 3'b100, 3'b010, 3'b100};
`else
        seq4 = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
        Req = 3'b110;
        for (int i = 0; i < 4; i++) begin
            watch(seq4[i], dir_of(seq4[i]), dato_of(seq4[i]), 0, 1);
            chk($sformatf("hold_ack_%0d", i), ack_val, seq4[i]);
            chk($sformatf("hold_latency_%0d", i), lat, 21);
        end
        Req = 3'b000;
        tick(); tick();

        // 4. Reset in the middle of a write
        We = 3'b001; Dir0 = 8'h21; Dato0 = 8'h45; Req = 3'b001;
        for (int n = 1; n <= 10; n++) tick();
        chk("mid_cs_low", CS, 1'b0);
        chk("mid_wr_low", WR, 1'b0);
        Reset = 1'b0;
        #1;
        chk("abort_cs", CS, 1'b1);
        chk("abort_wr", WR, 1'b1);
        chk("abort_ad", AD, 1'b1);
        chk("abort_oe", Bus_OE, 1'b0);
        chk("abort_gnt", Gnt, 3'b000);
        Req = 3'b000;
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (Ack != 3'b000) bad++;
        end
        Reset = 1'b1;
        tick();
        if (Ack != 3'b000) bad++;
        chk("abort_no_ack", bad, 0);
        We = 3'b000; Dir1 = 8'h11; Bus_In = 8'h7e; Req = 3'b010;
        watch(3'b010, 8'h11, 8'h00, 0, 0);
        chk("post_rst_latency", lat, 21);
        chk("post_rst_ack", ack_val, 3'b010);
        chk("post_rst_leido", leido_at_ack, 8'h7e);
        tick();

        // 5a. Req dropped mid-transaction still completes
        Dir1 = 8'h12; Bus_In = 8'ha5; Req = 3'b010;
        watch(3'b010, 8'h12, 8'h00, 3, 0);
        chk("drop_mid_latency", lat, 21);
        chk("drop_mid_ack", ack_val, 3'b010);
        chk("drop_mid_leido", leido_at_ack, 8'ha5);
        tick();

        // 5b. Req dropped before leaving IDLE is ignored
        Req = 3'b010;
        #4;
        Req = 3'b000;
        bad = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (Gnt != 3'b000 || Ack != 3'b000 || !CS) bad++;
        end
        chk("drop_idle_no_txn", bad, 0);

        // 6. T_PHASE=1 write on u_dut_f
        We = 3'b001; Dir0 = 8'h21; Dato0 = 8'h45; req_f = 3'b001;
        lat = 0; n_cs = 0; n_ad0_addr = 0; n_wr_data = 0; ack_val = '0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ack_f != 3'b000) begin
                lat = n;
                ack_val = ack_f;
                req_f = 3'b000;
                break;
            end
            if (!cs_f) n_cs++;
            if (!ad_f && oe_f && bus_out_f == 8'h21) n_ad0_addr++;
            if (!wr_f && ad_f && oe_f && bus_out_f == 8'h45) n_wr_data++;
        end
        chk("fast_latency", lat, 6);
        chk("fast_ack", ack_val, 3'b001);
        chk("fast_cs_cycles", n_cs, 4);
        chk("fast_addr_cycles", n_ad0_addr, 2);
        chk("fast_wr_cycles", n_wr_data, 1);
        tick();
        chk("fast_ack_one_cycle", ack_f, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
